// File: rtl/debug_frame_pkg.sv
// Shared types and constants for the debug frame transmitter.
// DEBUG_FRAME_CHECKSUM_EN selects the 9-byte frame (checksum appended).
package debug_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_t;

  localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int unsigned FRAME_LEN_PLAIN   = 8;
  localparam int unsigned FRAME_LEN_CHK     = 9;
  localparam int unsigned NUM_PORTS         = 7;
  localparam int unsigned BAUD_W            = 16;
  localparam int unsigned BYTE_IDX_W        = 4;

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serializer; accepts a byte from IDLE or at the end of a stop
// bit, so consecutive bytes of a frame go out with no gap.
module uart_tx_byte
  import debug_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       byteValid,
  input  logic [7:0] byteData,
  output logic       ready,
  output logic       byteDone_c,
  output logic       tx
);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  txState_t          state;
  logic [BAUD_W-1:0] baudCnt;
  logic [2:0]        bitIdx;
  logic [7:0]        shiftReg;
  logic              bitEnd_c;

  assign bitEnd_c   = (baudCnt == BAUD_LAST);
  assign byteDone_c = (state == STOP) && bitEnd_c;

  // Bit sequencer: tx always holds the level of the bit period now running.
  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      tx       <= 1'b1;
      ready    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (byteValid) begin
            shiftReg <= byteData;
            baudCnt  <= '0;
            bitIdx   <= '0;
            tx       <= 1'b0;
            ready    <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (bitEnd_c) begin
            baudCnt <= '0;
            tx      <= shiftReg[0];
            state   <= DATA;
          end else begin
            baudCnt <= baudCnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (bitEnd_c) begin
            baudCnt <= '0;
            if (bitIdx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bitIdx <= bitIdx + 3'd1;
              tx     <= shiftReg[bitIdx + 3'd1];
            end
          end else begin
            baudCnt <= baudCnt + BAUD_W'(1);
          end
        end
        STOP: begin
          if (bitEnd_c) begin
            baudCnt <= '0;
            bitIdx  <= '0;
            if (byteValid) begin
              shiftReg <= byteData;
              tx       <= 1'b0;
              state    <= START;
            end else begin
              tx    <= 1'b1;
              ready <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baudCnt <= baudCnt + BAUD_W'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/debug_frame_tx.sv
// Debug-port frame transmitter: snapshots seven CPU debug bytes on trigger and
// sends SYNC + ports (+ XOR checksum when DEBUG_FRAME_CHECKSUM_EN) over UART.
module debug_frame_tx
  import debug_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [7:0] debug_port1,
  input  logic [7:0] debug_port2,
  input  logic [7:0] debug_port3,
  input  logic [7:0] debug_port4,
  input  logic [7:0] debug_port5,
  input  logic [7:0] debug_port6,
  input  logic [7:0] debug_port7,
  input  logic       trigger,
  output logic       tx,
  output logic       busy,
  output logic       dropped
);

`ifdef DEBUG_FRAME_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = FRAME_LEN_CHK;
`else
  localparam int unsigned FRAME_LEN = FRAME_LEN_PLAIN;
`endif
  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(FRAME_LEN - 1);

  logic [NUM_PORTS-1:0][7:0] snap;
  logic [BYTE_IDX_W-1:0]     byteIdx;
  logic [BYTE_IDX_W-1:0]     nextIdx_c;
  logic [7:0]                nextByte_c;
  logic [7:0]                byteData_c;
  logic                      accept_c;
  logic                      byteValid_c;
  logic                      ready;
  logic                      byteDone_c;
`ifdef DEBUG_FRAME_CHECKSUM_EN
  logic [7:0]                checksum;
`endif

  assign accept_c = trigger && !busy;

  // Byte mux: SYNC goes out straight from the accept; later bytes come from the snapshot.
  always_comb begin
    nextIdx_c  = byteIdx + BYTE_IDX_W'(1);
    nextByte_c = 8'h00;
    if (nextIdx_c >= BYTE_IDX_W'(1) && nextIdx_c <= BYTE_IDX_W'(NUM_PORTS)) begin
      nextByte_c = snap[3'(nextIdx_c - BYTE_IDX_W'(1))];
    end
`ifdef DEBUG_FRAME_CHECKSUM_EN
    else if (nextIdx_c == BYTE_IDX_W'(FRAME_LEN_CHK - 1)) begin
      nextByte_c = checksum;
    end
`endif
    byteValid_c = accept_c ? ready : (busy && (byteIdx != LAST_IDX));
    byteData_c  = accept_c ? SYNC_BYTE : nextByte_c;
  end

  // Frame sequencer: snapshot, byte index, busy and the drop indicator.
  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      snap    <= '0;
      byteIdx <= '0;
      busy    <= 1'b0;
      dropped <= 1'b0;
`ifdef DEBUG_FRAME_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      dropped <= trigger && busy;
      if (accept_c) begin
        snap    <= {debug_port7, debug_port6, debug_port5, debug_port4,
                    debug_port3, debug_port2, debug_port1};
        byteIdx <= '0;
        busy    <= 1'b1;
`ifdef DEBUG_FRAME_CHECKSUM_EN
        checksum <= debug_port1 ^ debug_port2 ^ debug_port3 ^ debug_port4 ^
                    debug_port5 ^ debug_port6 ^ debug_port7;
`endif
      end else if (busy && byteDone_c) begin
        if (byteIdx == LAST_IDX) begin
          busy <= 1'b0;
        end else begin
          byteIdx <= byteIdx + BYTE_IDX_W'(1);
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uTxByte (
    .clk       (clk),
    .nreset    (nreset),
    .byteValid (byteValid_c),
    .byteData  (byteData_c),
    .ready     (ready),
    .byteDone_c(byteDone_c),
    .tx        (tx)
  );

endmodule

// File: tb/tb_debug_frame_tx.sv
// Bench for debug_frame_tx: frame-level reference model checked every cycle,
// a UART decoder on tx, and hand-computed expectations for the directed cases.
module tb_debug_frame_tx;

  localparam int CPB = 4;
`ifdef DEBUG_FRAME_CHECKSUM_EN
  localparam int N = 9;
`else
  localparam int N = 8;
`endif
  localparam int FRAME_CYC = 10 * N * CPB;

  logic       clk = 1'b0;
  logic       nreset = 1'b1;
  logic       trigger = 1'b0;
  logic [7:0] port [7];
  logic       tx, busy, dropped;

  int checks = 0;
  int errors = 0;

  debug_frame_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .nreset(nreset),
    .debug_port1(port[0]), .debug_port2(port[1]), .debug_port3(port[2]),
    .debug_port4(port[3]), .debug_port5(port[4]), .debug_port6(port[5]),
    .debug_port7(port[6]),
    .trigger(trigger), .tx(tx), .busy(busy), .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of bytes plus its start cycle.
  int         cyc = 0;
  logic       mActive = 1'b0;
  int         mStart = 0;
  logic [7:0] mBytes [9];
  logic       mDrop = 1'b0;

  function automatic logic [7:0] xorPorts();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < 7; i++) x ^= port[i];
    return x;
  endfunction

  function automatic logic mBusy(int c);
    return mActive && (c - mStart) >= 0 && (c - mStart) < FRAME_CYC;
  endfunction

  function automatic logic mTx(int c);
    int off, bitPos, b;
    if (!mBusy(c)) return 1'b1;
    off    = c - mStart;
    bitPos = off / CPB;
    b      = bitPos % 10;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return mBytes[bitPos / 10][b - 1];
  endfunction

  always @(posedge clk) begin
    if (nreset) begin
      mActive <= 1'b0;
      mDrop   <= 1'b0;
    end else begin
      mDrop <= trigger && mBusy(cyc);
      if (trigger && !mBusy(cyc)) begin
        mActive   <= 1'b1;
        mStart    <= cyc + 1;
        mBytes[0] <= 8'hA5;
        for (int i = 0; i < 7; i++) mBytes[i + 1] <= port[i];
        mBytes[8] <= xorPorts();
      end
    end
    cyc <= cyc + 1;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (nreset) begin
      check("rst_tx", 32'(tx), 32'(1));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_dropped", 32'(dropped), 32'(0));
    end else begin
      check("tx", 32'(tx), 32'(mTx(cyc)));
      check("busy", 32'(busy), 32'(mBusy(cyc)));
      check("dropped", 32'(dropped), 32'(mDrop));
    end
  end

  // Independent UART receiver sampling mid-bit.
  logic       rxActive = 1'b0;
  int         rxOff = 0;
  logic [7:0] rxByte = 8'h00;
  logic [7:0] rxQ [$];

  always @(negedge clk) begin
    if (nreset) begin
      rxActive <= 1'b0;
    end else if (!rxActive) begin
      if (tx == 1'b0) begin
        rxActive <= 1'b1;
        rxOff    <= 1;
      end
    end else begin
      rxOff <= rxOff + 1;
      if (rxOff % CPB == CPB / 2) begin
        if (rxOff / CPB >= 1 && rxOff / CPB <= 8) rxByte[rxOff / CPB - 1] <= tx;
        else if (rxOff / CPB == 9) begin
          rxQ.push_back(rxByte);
          rxActive <= 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (busy && n < 2 * FRAME_CYC) begin
      tick();
      n++;
    end
    check(name, 32'(busy), 32'(0));
  endtask

  logic [7:0] exp1 [9] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00};
  logic [7:0] cap [7];

  initial begin
    for (int i = 0; i < 7; i++) port[i] = 8'h00;
    repeat (3) tick();
    check("reset_tx", 32'(tx), 32'(1));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_dropped", 32'(dropped), 32'(0));
    nreset = 1'b0;
    repeat (2) tick();

    // Ports 01..07, one trigger: busy length, no drops, decoded bytes.
    begin
      int n = 0, dropSeen = 0;
      for (int i = 0; i < 7; i++) port[i] = 8'(i + 1);
      rxQ.delete();
      pulse();
      check("first_tx_start", 32'(tx), 32'(0));
      while (busy && n < 2 * FRAME_CYC) begin
        if (dropped) dropSeen++;
        n++;
        tick();
      end
`ifdef DEBUG_FRAME_CHECKSUM_EN
      check("busy_len", 32'(n), 32'(360));
`else
      check("busy_len", 32'(n), 32'(320));
`endif
      check("no_drop", 32'(dropSeen), 32'(0));
      repeat (2) tick();
      check("rx_count1", 32'(rxQ.size()), 32'(N));
      for (int j = 0; j < N && j < rxQ.size(); j++) check("rx_byte1", 32'(rxQ[j]), 32'(exp1[j]));
    end

    // port7 = 0x80: checksum 0x87 when enabled.
    port[6] = 8'h80;
    rxQ.delete();
    pulse();
    waitIdle("wait_t2");
    repeat (2) tick();
    check("rx_count2", 32'(rxQ.size()), 32'(N));
`ifdef DEBUG_FRAME_CHECKSUM_EN
    if (rxQ.size() == 9) check("checksum", 32'(rxQ[8]), 32'(8'h87));
`else
    if (rxQ.size() == 8) check("port7_byte", 32'(rxQ[7]), 32'(8'h80));
`endif

    // Ports scrambled every cycle after accept.
    for (int i = 0; i < 7; i++) begin port[i] = 8'($urandom); cap[i] = port[i]; end
    rxQ.delete();
    pulse();
    while (busy) begin
      for (int i = 0; i < 7; i++) port[i] = 8'($urandom);
      tick();
    end
    repeat (2) tick();
    check("rx_count3", 32'(rxQ.size()), 32'(N));
    for (int j = 1; j < 8 && j < rxQ.size(); j++) check("rx_snapshot", 32'(rxQ[j]), 32'(cap[j - 1]));

    // Trigger 50 cycles in is dropped; trigger on first idle cycle starts a frame.
    for (int i = 0; i < 7; i++) begin port[i] = 8'($urandom); cap[i] = port[i]; end
    rxQ.delete();
    pulse();
    repeat (49) tick();
    pulse();
    check("drop_pulse", 32'(dropped), 32'(1));
    tick();
    check("drop_once", 32'(dropped), 32'(0));
    waitIdle("wait_t4");
    pulse();
    check("retrig_busy", 32'(busy), 32'(1));
    check("retrig_tx", 32'(tx), 32'(0));
    for (int j = 1; j < 8 && j < rxQ.size(); j++) check("rx_unaltered", 32'(rxQ[j]), 32'(cap[j - 1]));
    waitIdle("wait_t4b");
    tick();

    // Reset in the middle of byte 3 data bits.
    for (int i = 0; i < 7; i++) port[i] = 8'($urandom);
    port[2] = 8'h00;
    pulse();
    repeat (133) tick();
    check("pre_reset_tx", 32'(tx), 32'(0));
    nreset = 1'b1;
    #1;
    check("async_tx", 32'(tx), 32'(1));
    check("async_busy", 32'(busy), 32'(0));
    repeat (2) tick();
    nreset = 1'b0;
    begin
      int hi = 0;
      for (int k = 0; k < 60; k++) begin
        tick();
        if (tx === 1'b1 && busy === 1'b0) hi++;
      end
      check("no_resume", 32'(hi), 32'(60));
    end

    // Trigger held through two frames.
    begin
      int idleCnt = 0, dropCnt = 0;
      rxQ.delete();
      trigger = 1'b1;
      tick();
      for (int k = 1; k <= FRAME_CYC + 10; k++) begin
        tick();
        if (!busy) idleCnt++;
        if (dropped) dropCnt++;
      end
      trigger = 1'b0;
      check("gap_idle", 32'(idleCnt), 32'(1));
      check("held_drops", 32'(dropCnt), 32'(FRAME_CYC + 9));
      waitIdle("wait_t6");
      repeat (2) tick();
      check("rx_count6", 32'(rxQ.size()), 32'(2 * N));
    end

    // Random triggers and port activity against the model.
    for (int k = 0; k < 3000; k++) begin
      trigger = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < 7; i++) port[i] = 8'($urandom);
      tick();
    end
    trigger = 1'b0;
    waitIdle("wait_rand");
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/debug_frame_tx.md
# debug_frame_tx

- Serial transmitter for the CPU's seven 8-bit debug ports; it is the transmit end of the link to the host serial-port debugger.
- On a one-cycle `trigger`, it snapshots `debug_port1`..`debug_port7` and sends them as a framed UART 8N1 byte stream.
- It sits beside `cpu` at the top level, driving the board's TX pin.

## Interface
- `CLKS_PER_BIT`, default 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- `SYNC_BYTE`, default 8'hA5, first byte of every frame.
- `clk`  in  1  system clock; all logic on the rising edge.
- `nreset`  in  1  reset, asynchronous, active-high (asserted = 1).
- `debug_port1`..`debug_port7`  in  8 each  CPU debug bytes; sampled only on accepted trigger.
- `trigger`  in  1  snapshot/send request; level-sampled each cycle.
- `tx`  out  1  UART serial line; idles high.
- `busy`  out  1  high from the cycle after an accepted trigger until the frame's last stop bit completes.
- `dropped`  out  1  one-cycle pulse when `trigger`=1 while `busy`=1.

## Operation
- Frame bytes, in order: `SYNC_BYTE`, port1, port2, ..., port7, then optional checksum (see Configuration). N = 8 bytes, or 9 with checksum.
- Each byte is sent as: start bit 0, data bits LSB first, stop bit 1. Each bit lasts exactly `CLKS_PER_BIT` cycles.
- Accept rule: `trigger`=1 and `busy`=0 at a clock edge.
  - The seven ports are latched into the snapshot register on that edge.
  - Later changes on the ports do not affect the frame in flight.
- Reject rule: `trigger`=1 and `busy`=1.
  - Trigger is ignored; the snapshot is unchanged; `dropped`=1 for the next cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on accept.
  - START→DATA after `CLKS_PER_BIT` cycles.
  - DATA→STOP after 8 bit periods.
  - STOP→START (next byte) if byte index < N-1; otherwise STOP→IDLE.
- Counters:
  - baud counter: 0..`CLKS_PER_BIT`-1, wraps to 0 at each bit boundary.
  - bit index: 0..7.
  - byte index: 0..N-1, cleared on accept.
- `tx` is a registered output: 1 in IDLE and STOP, 0 in START, the current data bit in DATA.
- Reset values: `tx`=1, `busy`=0, `dropped`=0, state IDLE, snapshot and all counters 0.
- Reset asserted mid-frame: `tx` goes to 1 asynchronously and the frame is abandoned. After reset releases, the block is in IDLE and does not resume.
- Trigger held high continuously: frames go back-to-back with exactly one IDLE cycle (tx=1) between them. A `dropped` pulse is produced on every busy cycle in which trigger is high.

## Timing
- Accept at edge E:
  - `busy`=1 and `tx`=0 (start bit of the SYNC byte) from edge E+1.
  - Bit k of byte j starts at E+1+(10j+1+k)·`CLKS_PER_BIT`.
- Frame duration: 10·N·`CLKS_PER_BIT` cycles.
  - `busy` falls at E+1+10·N·`CLKS_PER_BIT`, i.e. the first cycle back in IDLE.
  - A trigger in that same cycle is accepted.
- `dropped` is registered: the pulse appears the cycle after the rejected trigger.

## Configuration
- `DEBUG_FRAME_CHECKSUM_EN` defined:
  - N = 9; byte 9 is the XOR of port1..port7 from the snapshot (SYNC excluded).
- Undefined:
  - N = 8; no checksum logic or register is synthesized.

## Structure
- Package `debug_frame_pkg`:
  - FSM state encoding (IDLE/START/DATA/STOP).
  - Default `SYNC_BYTE`.
  - Frame length constants (8 and 9).
- Sub-module `uart_tx_byte`:
  - Handles START/DATA/STOP, baud counter and bit index.
  - Byte valid/ready handshake with the top-level frame sequencer.
  - `ready` is high only in its IDLE state.
- Top-level `debug_frame_tx`:
  - Owns the snapshot register, byte index, byte mux, checksum, `busy` and `dropped`.

## Test plan
- `CLKS_PER_BIT`=4, ports = 0x01..0x07, one trigger pulse → `tx` decodes to A5 01 02 03 04 05 06 07. `busy` lasts 320 cycles (360 with checksum), and `dropped` stays 0.
- Same ports with port7 = 0x80, `DEBUG_FRAME_CHECKSUM_EN` defined → 9th byte = 0x87.
- Ports changed every cycle after accept → transmitted bytes equal the values captured at the accept edge.
- Second trigger 50 cycles into a frame → `dropped` pulses once, one cycle later, and the frame is unaltered. A third trigger in the first cycle with `busy`=0 starts a new frame.
- `nreset` asserted mid-DATA of byte 3 → `tx`=1 and `busy`=0 immediately. After release, `tx` stays high until a new trigger.
- `trigger` held high for 2 frames → two complete frames separated by exactly 1 idle cycle, with `dropped` high on every busy cycle.
